// File: rtl/dec_pkg.sv
// Shared definitions for the 2:4 stream decoder: default code width, output
// width derivation, skid-buffer state encoding and the one-hot decode helper.
// The decode helper is also used by the encoder bench as its golden model.
package dec_pkg;

  localparam int CODE_W_DEF = 2;
  localparam int MAX_OUT_W  = 64;

  // Occupancy of the two-entry skid buffer (main register + skid register)
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skidState_t;

  // One-hot output width for a given binary code width
  function automatic int outWidth(input int codeW);
    return 1 << codeW;
  endfunction

  // Binary code to one-hot word; callers truncate to their own output width
  function automatic logic [MAX_OUT_W-1:0] decodeOneHot(input int unsigned code);
    return {{(MAX_OUT_W-1){1'b0}}, 1'b1} << code;
  endfunction

endpackage

// File: rtl/decoder_2_4_stream_if.sv
// Stream bundle for the decoder: upstream code beat (with enable) and the
// downstream one-hot beat. The producer/consumer side drives through the
// master modport; the decoder sits on the slave modport.
interface decoder_2_4_stream_if #(
  parameter int CODE_W = 2
) ();

  localparam int OUT_W = 1 << CODE_W;

  logic              en;
  logic [CODE_W-1:0] in_code;
  logic              in_valid;
  logic              in_ready;
  logic [OUT_W-1:0]  out_I;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output en, in_code, in_valid, out_ready,
    input  in_ready, out_I, out_valid
  );

  modport slave (
    input  en, in_code, in_valid, out_ready,
    output in_ready, out_I, out_valid
  );

endinterface

// File: rtl/dec_skid_buf.sv
// Two-entry valid/ready skid buffer. The main register drives the output;
// the skid register catches the one beat that can arrive while the output is
// stalled. Upstream ready is registered and drops only when both are full.
module dec_skid_buf
  import dec_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_inData,
  input  logic             i_inValid,
  output logic             o_inReady,
  output logic [WIDTH-1:0] o_outData,
  output logic             o_outValid,
  input  logic             i_outReady
);

  skidState_t       r_state;
  skidState_t       w_nextState;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] r_skid;
  logic             r_inReady;
  logic             w_accept;
  logic             w_transfer;
  logic             w_loadMain;
  logic             w_loadSkid;
  logic             w_moveSkid;
  logic             w_clearMain;

  assign o_inReady  = r_inReady;
  assign o_outValid = (r_state != EMPTY);
  assign o_outData  = r_main;
  assign w_accept   = i_inValid & r_inReady;
  assign w_transfer = o_outValid & i_outReady;

  // Occupancy state and the registered upstream ready that follows it
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= EMPTY;
      r_inReady <= 1'b1;
    end else begin
      r_state   <= w_nextState;
      r_inReady <= (w_nextState != FULL);
    end
  end

  // Next occupancy and which data register moves this cycle
  always_comb begin
    w_nextState = r_state;
    w_loadMain  = 1'b0;
    w_loadSkid  = 1'b0;
    w_moveSkid  = 1'b0;
    w_clearMain = 1'b0;
    case (r_state)
      EMPTY: begin
        if (w_accept) begin
          w_nextState = ONE;
          w_loadMain  = 1'b1;
        end
      end
      ONE: begin
        if (w_accept && !w_transfer) begin
          w_nextState = FULL;
          w_loadSkid  = 1'b1;
        end else if (w_accept && w_transfer) begin
          w_loadMain  = 1'b1;
        end else if (w_transfer) begin
          w_nextState = EMPTY;
          w_clearMain = 1'b1;
        end
      end
      FULL: begin
        if (w_transfer) begin
          w_nextState = ONE;
          w_moveSkid  = 1'b1;
        end
      end
      default: begin
        w_nextState = EMPTY;
      end
    endcase
  end

  // Data registers; main holds steady whenever the output is stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      r_main <= '0;
      r_skid <= '0;
    end else begin
      if (w_loadMain) begin
        r_main <= i_inData;
      end else if (w_moveSkid) begin
        r_main <= r_skid;
      end else if (w_clearMain) begin
        r_main <= '0;
      end
      if (w_loadSkid) begin
        r_skid <= i_inData;
      end
    end
  end

endmodule

// File: rtl/decoder_2_4_stream.sv
// Registered binary-to-one-hot decoder on a valid/ready stream.
// Decodes (with enable gating) at the input and buffers the result in a
// two-entry skid buffer. Optional feature macro: DEC_HIT_CNT_EN adds
// per-output saturating hit counters readable through cnt_sel/cnt_q.
module decoder_2_4_stream
  import dec_pkg::*;
#(
  parameter int CODE_W = CODE_W_DEF,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  decoder_2_4_stream_if.slave bus,
  input  logic [CODE_W-1:0] cnt_sel,
  output logic [CNT_W-1:0]  cnt_q
);

  localparam int OUT_W = outWidth(CODE_W);

  logic [OUT_W-1:0] w_decoded;

  // Disabled beats still flow, but carry an all-zero word
  always_comb begin
    w_decoded = '0;
    if (bus.en) begin
      w_decoded = OUT_W'(decodeOneHot(32'(bus.in_code)));
    end
  end

  dec_skid_buf #(
    .WIDTH (OUT_W)
  ) u_skid (
    .clk        (clk),
    .rst        (rst),
    .i_inData   (w_decoded),
    .i_inValid  (bus.in_valid),
    .o_inReady  (bus.in_ready),
    .o_outData  (bus.out_I),
    .o_outValid (bus.out_valid),
    .i_outReady (bus.out_ready)
  );

`ifdef DEC_HIT_CNT_EN
  logic             w_transfer;
  logic [CNT_W-1:0] r_hitCnt [OUT_W];
  logic [CNT_W-1:0] r_cntQ;

  assign w_transfer = bus.out_valid & bus.out_ready;
  assign cnt_q      = r_cntQ;

  // Count transferred beats per set bit, sticking at all-ones
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < OUT_W; i++) begin
        r_hitCnt[i] <= '0;
      end
    end else if (w_transfer) begin
      for (int i = 0; i < OUT_W; i++) begin
        if (bus.out_I[i] && (r_hitCnt[i] != {CNT_W{1'b1}})) begin
          r_hitCnt[i] <= r_hitCnt[i] + 1'b1;
        end
      end
    end
  end

  // Registered read port of the selected counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cntQ <= '0;
    end else begin
      r_cntQ <= r_hitCnt[cnt_sel];
    end
  end
`else
  // Without counters the read port is constant zero; cnt_sel is masked off
  assign cnt_q = CNT_W'(cnt_sel) & {CNT_W{1'b0}};
`endif

endmodule
